// File: rtl/mips_prog_loader.sv
// Host-side program loader for the single-clock mips core: streams an image into
// core memory, runs the core until HLT (or timeout), then dumps R0..R(NUM_DUMP-1).
module mips_prog_loader #(
    parameter int AW          = 10,
    parameter int NUM_DUMP    = 8,
    parameter int RUN_TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_run,
    input  logic          cpu_halted,
    output logic [4:0]    reg_raddr,
    input  logic [31:0]   reg_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic          busy,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMP_RD,
        S_DUMP_OUT
    } state_t;

    localparam int            TW         = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((RUN_TIMEOUT > 0) ? RUN_TIMEOUT - 1 : 0);
    localparam logic [4:0]    IDX_LAST   = 5'(NUM_DUMP - 1);
    localparam logic [32:0]   MAX_N      = 33'(1) << AW;

    state_t        state_reg;
    logic [AW:0]   addr_reg;
    logic [AW:0]   count_reg;
    logic [TW-1:0] timer_reg;
    logic [4:0]    idx_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            count_reg <= '0;
            timer_reg <= '0;
            idx_reg   <= '0;
            in_ready  <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_run   <= 1'b0;
            reg_raddr <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        err <= 1'b0;
                        // Count is judged on the full 32-bit word so huge values never alias.
                        if (in_data == 32'd0 || {1'b0, in_data} > MAX_N) begin
                            err <= 1'b1;
                        end else begin
                            count_reg <= in_data[AW:0];
                            addr_reg  <= '0;
                            busy      <= 1'b1;
                            state_reg <= S_LOAD;
                        end
                    end
                end

                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_reg[AW-1:0];
                        mem_wdata <= in_data;
                        addr_reg  <= addr_reg + 1'b1;
                        if (addr_reg + 1'b1 == count_reg) begin
                            in_ready  <= 1'b0;
                            timer_reg <= '0;
                            state_reg <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    // First RUN cycle overlaps the final memory write; release the core after it.
                    if (!cpu_run) begin
                        cpu_run <= 1'b1;
                    end else if (cpu_halted) begin
                        cpu_run   <= 1'b0;
                        idx_reg   <= '0;
                        reg_raddr <= '0;
                        state_reg <= S_DUMP_RD;
                    end else if (RUN_TIMEOUT != 0 && timer_reg == TIMER_LAST) begin
                        err       <= 1'b1;
                        cpu_run   <= 1'b0;
                        idx_reg   <= '0;
                        reg_raddr <= '0;
                        state_reg <= S_DUMP_RD;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                S_DUMP_RD: begin
                    out_data  <= reg_rdata;
                    out_valid <= 1'b1;
                    state_reg <= S_DUMP_OUT;
                end

                S_DUMP_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx_reg == IDX_LAST) begin
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            state_reg <= S_IDLE;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            reg_raddr <= idx_reg + 1'b1;
                            state_reg <= S_DUMP_RD;
                        end
                    end
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Bench for mips_prog_loader: a tiny behavioural core executes the loaded image,
// write and dump scoreboards check the loader's outputs against expected values.
module tb_mips_prog_loader;

    localparam int AW          = 10;
    localparam int NUM_DUMP    = 8;
    localparam int RUN_TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_run;
    logic          cpu_halted;
    logic [4:0]    reg_raddr;
    logic [31:0]   reg_rdata;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_data;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    mips_prog_loader #(
        .AW          (AW),
        .NUM_DUMP    (NUM_DUMP),
        .RUN_TIMEOUT (RUN_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_run    (cpu_run),
        .cpu_halted (cpu_halted),
        .reg_raddr  (reg_raddr),
        .reg_rdata  (reg_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .err        (err)
    );

    // ---------------- behavioural core: op[31:28] rd[27:23] rs[22:18] rt[17:13] imm[12:0]
    logic [31:0] cmem [0:1023];
    logic [31:0] regs [0:31];
    logic [9:0]  pc;
    logic        halted;
    bit          model_ready;
    logic [31:0] ir;
    logic [3:0]  op;
    logic [4:0]  rd, rs, rt;
    logic [31:0] imm;

    assign ir         = cmem[pc];
    assign op         = ir[31:28];
    assign rd         = ir[27:23];
    assign rs         = ir[22:18];
    assign rt         = ir[17:13];
    assign imm        = {{19{ir[12]}}, ir[12:0]};
    assign cpu_halted = halted;
    assign reg_rdata  = regs[reg_raddr];

    always @(posedge clk) begin
        if (!model_ready) begin
            for (int i = 0; i < 32; i++) regs[i] <= (i == 1) ? 32'd10 : 32'd0;
            for (int i = 0; i < 1024; i++) cmem[i] <= (i == 10) ? 32'd50 : 32'd0;
            pc          <= '0;
            halted      <= 1'b0;
            model_ready <= 1'b1;
        end else begin
            if (mem_we) cmem[mem_addr] <= mem_wdata;
            if (!cpu_run) begin
                pc     <= '0;
                halted <= 1'b0;
            end else if (!halted) begin
                pc <= pc + 10'd1;
                case (op)
                    4'd0: if (rd != 5'd0) regs[rd] <= regs[rs] + regs[rt];
                    4'd1: if (rd != 5'd0) regs[rd] <= regs[rs] - regs[rt];
                    4'd2: if (rd != 5'd0) regs[rd] <= regs[rs] + imm;
                    4'd3: if (rd != 5'd0) regs[rd] <= cmem[10'(regs[rs] + imm)];
                    4'd4: if (regs[rs] == 32'd0) pc <= pc + 10'd1 + imm[9:0];
                    4'd15: begin
                        halted <= 1'b1;
                        pc     <= pc;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- scoreboards and helpers
    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;
    typedef struct {
        logic [31:0] count;
        logic        exp_err;
        logic        exp_busy;
    } cvec_t;
    typedef logic [31:0] dump_t [NUM_DUMP];

    wr_t         wq [$];
    logic [31:0] dq [$];
    logic [31:0] prog [0:15];
    int          errors = 0;
    int          checks = 0;
    int          run_cycles = 0;

    function automatic logic [31:0] enc(input int o, input int d, input int s, input int t, input int i);
        return {o[3:0], d[4:0], s[4:0], t[4:0], i[12:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Every wait in the flow goes through here so no write strobe is missed.
    task automatic step();
        wr_t e;
        @(negedge clk);
        if (cpu_run) run_cycles++;
        if (rst_n && mem_we) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL write_unexpected: got addr=%0d data=0x%0h, want no write", mem_addr, mem_wdata);
            end else begin
                e = wq.pop_front();
                $display("write addr=%0d data=0x%08h", mem_addr, mem_wdata);
                check("write_addr", 32'(mem_addr), 32'(e.a));
                check("write_data", mem_wdata, e.d);
            end
        end
    endtask

    task automatic send_word(input logic [31:0] d);
        int b = 0;
        step();
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && b < 50) begin
            step();
            b++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic push_exp(input dump_t v);
        for (int i = 0; i < NUM_DUMP; i++) dq.push_back(v[i]);
    endtask

    task automatic pulse_reset();
        step();
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic load_prog(input int n, input bit gap);
        run_cycles = 0;
        send_word(32'(n));
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0) step();
            wq.push_back('{a: AW'(i), d: prog[i]});
            send_word(prog[i]);
        end
        step();
        check("last_write_we", 32'(mem_we), 32'd1);
        check("run_low_during_last_write", 32'(cpu_run), 32'd0);
        step();
        check("run_high_after_last_write", 32'(cpu_run), 32'd1);
    endtask

    task automatic wait_run_end();
        int b = 0;
        while (cpu_run && b < 3000) begin
            step();
            b++;
        end
        check("run_ended", 32'(cpu_run), 32'd0);
    endtask

    task automatic receive_dump(input int stall_at, input logic exp_err);
        logic [31:0] exp;
        logic [31:0] held;
        logic        stable;
        int          b;
        out_ready = 1'b1;
        for (int k = 0; k < NUM_DUMP; k++) begin
            b = 0;
            step();
            while (!out_valid && b < 100) begin
                step();
                b++;
            end
            if (!out_valid) begin
                check("dump_valid_timeout", 32'(out_valid), 32'd1);
                break;
            end
            exp = (dq.size() > 0) ? dq.pop_front() : 32'hDEAD_BEEF;
            $display("dump R%0d = %0d", k, out_data);
            check("dump_raddr", 32'(reg_raddr), 32'(k));
            check("dump_data", out_data, exp);
            if (k == stall_at) begin
                out_ready = 1'b0;
                held      = out_data;
                stable    = 1'b1;
                repeat (20) begin
                    step();
                    if (!out_valid || out_data !== held) stable = 1'b0;
                end
                check("dump_stall_stable", 32'(stable), 32'd1);
                out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        step();
        check("dump_done_valid", 32'(out_valid), 32'd0);
        check("dump_done_busy", 32'(busy), 32'd0);
        check("dump_done_err", 32'(err), 32'(exp_err));
        check("dump_done_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cvec_t tbl [7];
        tbl[0] = '{count: 32'd0,          exp_err: 1'b1, exp_busy: 1'b0};
        tbl[1] = '{count: 32'd1,          exp_err: 1'b0, exp_busy: 1'b1};
        tbl[2] = '{count: 32'd1025,       exp_err: 1'b1, exp_busy: 1'b0};
        tbl[3] = '{count: 32'd1024,       exp_err: 1'b0, exp_busy: 1'b1};
        tbl[4] = '{count: 32'hFFFF_FFFF,  exp_err: 1'b1, exp_busy: 1'b0};
        tbl[5] = '{count: 32'h0001_0001,  exp_err: 1'b1, exp_busy: 1'b0};
        tbl[6] = '{count: 32'd3,          exp_err: 1'b0, exp_busy: 1'b1};

        // Reset state
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_cpu_run", 32'(cpu_run), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        rst_n = 1'b1;

        // Count-word vectors: bad counts stay in IDLE with err, good ones enter LOAD
        for (int i = 0; i < 7; i++) begin
            send_word(tbl[i].count);
            step();
            $display("count %0d -> err=%0b busy=%0b", tbl[i].count, err, busy);
            check("count_err", 32'(err), 32'(tbl[i].exp_err));
            check("count_busy", 32'(busy), 32'(tbl[i].exp_busy));
            check("count_in_ready", 32'(in_ready), 32'd1);
            check("count_cpu_run", 32'(cpu_run), 32'd0);
            if (tbl[i].exp_busy) pulse_reset();
        end

        // Main program, R1=10 and Mem[10]=50 preset by the core model
        prog[0] = enc(2, 2, 1, 0, 5);
        prog[1] = enc(1, 3, 2, 1, 0);
        prog[2] = enc(3, 4, 1, 0, 0);
        prog[3] = enc(0, 5, 4, 3, 0);
        prog[4] = enc(4, 0, 0, 0, 1);
        prog[5] = enc(2, 6, 0, 0, 99);
        prog[6] = enc(2, 7, 0, 0, 42);
        prog[7] = enc(15, 0, 0, 0, 0);
        push_exp('{0, 10, 15, 5, 50, 55, 0, 42});
        load_prog(8, 1'b0);
        wait_run_end();
        check("halt_no_err", 32'(err), 32'd0);
        receive_dump(-1, 1'b0);

        // Gapped host stream, and a 20-cycle out_ready stall on R3
        prog[0] = enc(2, 6, 0, 0, 7);
        prog[1] = enc(2, 7, 7, 0, 1);
        prog[2] = enc(0, 0, 0, 0, 0);
        prog[3] = enc(15, 0, 0, 0, 0);
        push_exp('{0, 10, 15, 5, 50, 55, 7, 43});
        load_prog(4, 1'b1);
        wait_run_end();
        receive_dump(3, 1'b0);

        // Endless loop: forced dump after RUN_TIMEOUT cycles
        prog[0] = enc(4, 0, 0, 0, 13'h1FFF);
        push_exp('{0, 10, 15, 5, 50, 55, 7, 43});
        load_prog(1, 1'b0);
        wait_run_end();
        check("timeout_run_cycles", 32'(run_cycles), 32'(RUN_TIMEOUT));
        check("timeout_err", 32'(err), 32'd1);
        receive_dump(-1, 1'b1);

        // Asynchronous reset after 3 of 6 words, then a clean reload
        prog[0] = enc(2, 6, 0, 0, 1);
        prog[1] = enc(2, 7, 0, 0, 2);
        prog[2] = enc(0, 5, 6, 7, 0);
        prog[3] = enc(2, 3, 0, 0, 9);
        prog[4] = enc(0, 0, 0, 0, 0);
        prog[5] = enc(15, 0, 0, 0, 0);
        send_word(32'd6);
        for (int i = 0; i < 3; i++) begin
            wq.push_back('{a: AW'(i), d: prog[i]});
            send_word(prog[i]);
        end
        step();
        #2 rst_n = 1'b0;
        #1;
        check("abort_cpu_run", 32'(cpu_run), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mem_we", 32'(mem_we), 32'd0);
        step();
        rst_n = 1'b1;
        push_exp('{0, 10, 15, 9, 50, 3, 1, 2});
        load_prog(6, 1'b0);
        wait_run_end();
        receive_dump(-1, 1'b0);

        check("write_queue_empty", 32'(wq.size()), 32'd0);
        check("dump_queue_empty", 32'(dq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
